obc_bitplane_accumulator: RTL and testbench

- Consumer end of the OBC ROM interface in the 16-point DFT datapath.
- Takes the eight 32-bit ROM words produced for one bit-plane of the 16 input samples (one plane per accepted cycle, MSB plane first) and adds them together.
- Combines the planes with Horner-style shift-accumulation, negating the sign plane, and adds the OBC offset constant.
- Emits one DFT output component (real or imaginary) per frame.

---
 rtl/obc_bitplane_accumulator.sv | 169 ++++++++++++++++
 tb/tb_obc_bitplane_accumulator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/obc_bitplane_accumulator.sv
// OBC bit-plane accumulator: sums eight ROM words per plane and Horner-combines DATA_W planes (MSB/sign plane first) plus offset.
// Optional macro OBC_SAT_EN adds a ROM_W-wide saturated copy of the result (out_sat) and a clamp flag (sat_flag).
module obc_bitplane_accumulator #(
    parameter int DATA_W = 16,
    parameter int ROM_W  = 32,
    parameter int ACC_W  = ROM_W + 3 + DATA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [ROM_W-1:0] rom_word0,
    input  logic signed [ROM_W-1:0] rom_word1,
    input  logic signed [ROM_W-1:0] rom_word2,
    input  logic signed [ROM_W-1:0] rom_word3,
    input  logic signed [ROM_W-1:0] rom_word4,
    input  logic signed [ROM_W-1:0] rom_word5,
    input  logic signed [ROM_W-1:0] rom_word6,
    input  logic signed [ROM_W-1:0] rom_word7,
    input  logic signed [ROM_W-1:0] offset_in,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [ACC_W-1:0] out_data
`ifdef OBC_SAT_EN
    ,
    output logic signed [ROM_W-1:0] out_sat,
    output logic        [0:0]       sat_flag
`endif
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_PLANE = CNT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_acc_nxt;
    logic        [CNT_W-1:0]   r_cnt;
    logic        [CNT_W-1:0]   w_cnt_nxt;
    logic                      r_busy;
    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_out_data;
    logic                      w_done;

    logic signed [ROM_W-1:0]   w_words [8];
    logic signed [ACC_W-1:0]   w_psum;
    logic signed [ACC_W-1:0]   w_horner;
    logic signed [ACC_W-1:0]   w_result;

    assign w_words = '{rom_word0, rom_word1, rom_word2, rom_word3,
                       rom_word4, rom_word5, rom_word6, rom_word7};

    // Combinational plane sum, sign-extended before adding so no carry is lost.
    always_comb begin
        w_psum = '0;
        for (int i = 0; i < 8; i++) begin
            w_psum = w_psum + ACC_W'(w_words[i]);
        end
    end

    assign w_horner = (r_acc <<< 1) + w_psum;
    assign w_result = w_horner + ACC_W'(offset_in);

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    // First plane carries the sign weight, hence the negation.
                    w_acc_nxt   = -w_psum;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    if (r_cnt == LAST_PLANE) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_acc_nxt = w_horner;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_done      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= (w_state_nxt == S_ACCUM);
            r_out_valid <= w_done;
            if (w_done) begin
                r_out_data <= w_result;
            end
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

`ifdef OBC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = (SAT_ONE <<< (ROM_W - 1)) - SAT_ONE;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(SAT_ONE <<< (ROM_W - 1));

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    function automatic logic signed [ROM_W-1:0] sat_clamp(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[ROM_W-1:0];
    endfunction

    logic signed [ROM_W-1:0] r_out_sat;
    logic                    r_sat_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sat  <= '0;
            r_sat_flag <= 1'b0;
        end else if (w_done) begin
            r_out_sat  <= sat_clamp(w_result);
            r_sat_flag <= sat_hit(w_result);
        end
    end

    assign out_sat  = r_out_sat;
    assign sat_flag = r_sat_flag;
`endif

endmodule

// File: tb/tb_obc_bitplane_accumulator.sv
// Directed bench for obc_bitplane_accumulator (DATA_W=4) with an expected-result scoreboard; covers OBC_SAT_EN when defined.
module tb_obc_bitplane_accumulator;

    localparam int DW    = 4;
    localparam int RW    = 32;
    localparam int AW    = RW + 3 + DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic signed [RW-1:0] rom_word0 = '0, rom_word1 = '0, rom_word2 = '0, rom_word3 = '0;
    logic signed [RW-1:0] rom_word4 = '0, rom_word5 = '0, rom_word6 = '0, rom_word7 = '0;
    logic signed [RW-1:0] offset_in = '0;
    logic busy;
    logic out_valid;
    logic signed [AW-1:0] out_data;
`ifdef OBC_SAT_EN
    logic signed [RW-1:0] out_sat;
    logic [0:0]           sat_flag;
`endif

    obc_bitplane_accumulator #(.DATA_W(DW), .ROM_W(RW), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .rom_word0 (rom_word0),
        .rom_word1 (rom_word1),
        .rom_word2 (rom_word2),
        .rom_word3 (rom_word3),
        .rom_word4 (rom_word4),
        .rom_word5 (rom_word5),
        .rom_word6 (rom_word6),
        .rom_word7 (rom_word7),
        .offset_in (offset_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef OBC_SAT_EN
        ,
        .out_sat   (out_sat),
        .sat_flag  (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        longint val;
        int     due;
    } exp_t;

    exp_t                 sb[$];
    int                   n_checks = 0;
    int                   n_pass = 0;
    int                   cyc = 0;
    longint               m_acc = 0;
    longint               last_out = 0;
    logic signed [RW-1:0] w [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        exp_t e;
        logic signed [AW-1:0] ev;
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                ev = AW'(e.val);
                check("latency_cycle", 64'(cyc), 64'(e.due));
                check("out_data", 64'(out_data), 64'(ev));
                last_out = e.val;
`ifdef OBC_SAT_EN
                begin
                    longint smax, smin, cl;
                    smax = 64'sd2147483647;
                    smin = -64'sd2147483648;
                    cl = (e.val > smax) ? smax : (e.val < smin) ? smin : e.val;
                    check("out_sat", 64'(out_sat), 64'(RW'(cl)));
                    check("sat_flag", 64'(sat_flag), 64'((e.val > smax) || (e.val < smin)));
                end
`endif
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("missing_out_valid", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic fill(input logic signed [RW-1:0] v);
        for (int i = 0; i < 8; i++) w[i] = v;
    endtask

    task automatic send(input int b, input logic signed [RW-1:0] off, input int gap);
        longint p;
        exp_t e;
        p = 0;
        for (int i = 0; i < 8; i++) p += longint'(w[i]);
        if (b == 0) m_acc = -p * (longint'(1) << (DW - 1));
        else        m_acc = m_acc + p * (longint'(1) << (DW - 1 - b));
        {rom_word0, rom_word1, rom_word2, rom_word3} = {w[0], w[1], w[2], w[3]};
        {rom_word4, rom_word5, rom_word6, rom_word7} = {w[4], w[5], w[6], w[7]};
        offset_in = off;
        in_valid = 1'b1;
        check($sformatf("busy_plane%0d", b), 64'(busy), 64'(b != 0));
        if (b == DW - 1) begin
            e.val = m_acc + longint'(off);
            e.due = cyc + 1;
            sb.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        tick();
    endtask

    initial begin
        // Reset values while rst_n is held low
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        #11 rst_n = 1'b1;
        tick();

        // All words 1 on four consecutive planes -> -8
        fill(32'sd1);
        for (int b = 0; b < DW; b++) send(b, 32'sd0, 0);
        drain();

        // Only word0=5 on the MSB plane, offset 3 -> -37
        for (int b = 0; b < DW; b++) begin
            fill(32'sd0);
            if (b == 0) w[0] = 32'sd5;
            send(b, 32'sd3, 0);
        end
        drain();

        // Same as first frame with three idle cycles between planes
        fill(32'sd1);
        for (int b = 0; b < DW; b++) send(b, 32'sd0, 3);
        drain();

        // Two frames back to back
        fill(32'sd1);
        for (int b = 0; b < DW; b++) send(b, 32'sd0, 0);
        fill(-32'sd2);
        for (int b = 0; b < DW; b++) send(b, 32'sd7, 0);
        drain();

        // Clear after plane 2, then a fresh random frame
        fill(32'sd100);
        send(0, 32'sd0, 0);
        send(1, 32'sd0, 0);
        fill(32'sd55);
        clear = 1'b1;
        in_valid = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        m_acc = 0;
        check("clear_busy", 64'(busy), 64'd0);
        check("clear_hold_out_data", 64'(out_data), 64'(AW'(last_out)));
        for (int b = 0; b < DW; b++) begin
            for (int i = 0; i < 8; i++) w[i] = $urandom;
            send(b, $urandom, 1);
        end
        drain();

        // Extremes: max words on non-MSB planes, then min words everywhere
        for (int b = 0; b < DW; b++) begin
            fill(b == 0 ? 32'sd0 : 32'sh7FFFFFFF);
            send(b, 32'sh7FFFFFFF, 0);
        end
        fill(32'sh80000000);
        for (int b = 0; b < DW; b++) send(b, 32'sh80000000, 0);
        drain();

        // Reset pulsed in the middle of a frame
        fill(32'sd9);
        send(0, 32'sd0, 0);
        send(1, 32'sd0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        #2 rst_n = 1'b1;
        m_acc = 0;
        last_out = 0;

        // Frame after reset recovers normally
        fill(-32'sd3);
        for (int b = 0; b < DW; b++) send(b, -32'sd11, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
